// File: rtl/ongoru_guncelleme_siralayici_pkg.sv
// Shared constants and types for the predictor update sequencer.
// Default depth, starvation limit and table index width live here.
package ongoru_guncelleme_siralayici_pkg;

  localparam int VARSAYILAN_DERINLIK     = 4;
  localparam int VARSAYILAN_ACLIK_SINIRI = 8;
  localparam int VARSAYILAN_ADR_W        = 5;
  localparam int PS_W                    = 31;

  typedef struct packed {
    logic [PS_W-1:0] ps;
    logic            btb;
    logic            yon;
  } yuk_t;

  typedef enum logic [1:0] {
    ERISIM_BOS = 2'd0,
    ERISIM_OKU = 2'd1,
    ERISIM_YAZ = 2'd2
  } erisim_e;

  function automatic int sayac_w(input int sinir);
    return $clog2(sinir + 1);
  endfunction

endpackage

// File: rtl/ongoru_guncelleme_siralayici_if.sv
// Update-request, fetch-read and table-write signals of the sequencer.
// slave = sequencer view, master = surrounding pipeline view.
interface ongoru_guncelleme_siralayici_if
  import ongoru_guncelleme_siralayici_pkg::*;
#(
  parameter int ADR_W = VARSAYILAN_ADR_W
);
  logic             yaz_gecerli_i;
  logic             yaz_hazir_o;
  logic [ADR_W-1:0] yaz_adr_i;
  logic [PS_W-1:0]  yaz_ps_i;
  logic             yaz_btb_i;
  logic             yaz_yon_i;
  logic             oku_istek_i;
  logic             oku_izin_o;
  logic             tablo_yaz_o;
  logic [ADR_W-1:0] tablo_adr_o;
  logic [PS_W-1:0]  tablo_ps_o;
  logic             tablo_btb_o;
  logic             tablo_yon_o;

  modport slave (
    input  yaz_gecerli_i, yaz_adr_i, yaz_ps_i, yaz_btb_i, yaz_yon_i, oku_istek_i,
    output yaz_hazir_o, oku_izin_o, tablo_yaz_o, tablo_adr_o, tablo_ps_o,
           tablo_btb_o, tablo_yon_o
  );

  modport master (
    output yaz_gecerli_i, yaz_adr_i, yaz_ps_i, yaz_btb_i, yaz_yon_i, oku_istek_i,
    input  yaz_hazir_o, oku_izin_o, tablo_yaz_o, tablo_adr_o, tablo_ps_o,
           tablo_btb_o, tablo_yon_o
  );
endinterface

// File: rtl/ongoru_kuyrugu.sv
// Circular update queue with head read-out and newest-entry overwrite.
// ONGORU_BIRLESTIRME_EN: a push matching the newest entry's index overwrites it.
module ongoru_kuyrugu
  import ongoru_guncelleme_siralayici_pkg::*;
#(
  parameter int DERINLIK = VARSAYILAN_DERINLIK,
  parameter int ADR_W    = VARSAYILAN_ADR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             temizle_i,
  input  logic             it_i,
  input  logic             cek_i,
  input  logic [ADR_W-1:0] adr_i,
  input  yuk_t             yuk_i,
  output logic [ADR_W-1:0] bas_adr_o,
  output yuk_t             bas_yuk_o,
  output logic             bos_o,
  output logic             dolu_o
);

  localparam int IW = $clog2(DERINLIK);

  logic [IW:0]      yaz_ptr, oku_ptr;
  logic [IW-1:0]    yaz_idx, oku_idx, hedef_idx;
  logic [ADR_W-1:0] adr_mem [DERINLIK];
  yuk_t             yuk_mem [DERINLIK];
  logic             kabul, cek_ok, birlestir, yeni;

  assign yaz_idx = yaz_ptr[IW-1:0];
  assign oku_idx = oku_ptr[IW-1:0];
  assign bos_o   = (yaz_ptr == oku_ptr);
  assign dolu_o  = (yaz_ptr[IW] != oku_ptr[IW]) && (yaz_idx == oku_idx);

  // Fullness is judged before any same-cycle pop.
  assign kabul  = it_i & ~dolu_o & ~temizle_i;
  assign cek_ok = cek_i & ~bos_o & ~temizle_i;

`ifdef ONGORU_BIRLESTIRME_EN
  logic [IW-1:0] son_idx;
  logic          tek_girdi;

  assign son_idx   = yaz_idx - IW'(1);
  assign tek_girdi = ((yaz_ptr - oku_ptr) == (IW+1)'(1));
  // The newest entry cannot be rewritten while it is leaving the queue.
  assign birlestir = kabul & ~bos_o & (adr_mem[son_idx] == adr_i) & ~(cek_ok & tek_girdi);
  assign hedef_idx = birlestir ? son_idx : yaz_idx;
`else
  assign birlestir = 1'b0;
  assign hedef_idx = yaz_idx;
`endif

  assign yeni = kabul & ~birlestir;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else if (temizle_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else begin
      if (yeni)   yaz_ptr <= yaz_ptr + (IW+1)'(1);
      if (cek_ok) oku_ptr <= oku_ptr + (IW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (kabul) begin
      adr_mem[hedef_idx] <= adr_i;
      yuk_mem[hedef_idx] <= yuk_i;
    end
  end

  assign bas_adr_o = bos_o ? '0 : adr_mem[oku_idx];
  assign bas_yuk_o = bos_o ? '0 : yuk_mem[oku_idx];

endmodule

// File: rtl/ongoru_guncelleme_siralayici.sv
// Shares the single-ported predictor tables between fetch reads and queued training writes.
// ONGORU_BIRLESTIRME_EN enables newest-entry coalescing inside the queue.
module ongoru_guncelleme_siralayici
  import ongoru_guncelleme_siralayici_pkg::*;
#(
  parameter int DERINLIK     = VARSAYILAN_DERINLIK,
  parameter int ACLIK_SINIRI = VARSAYILAN_ACLIK_SINIRI,
  parameter int ADR_W        = VARSAYILAN_ADR_W
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         temizle_i,
  ongoru_guncelleme_siralayici_if.slave bus,
  output logic                         bos_o,
  output logic                         dolu_o
);

  localparam int             AC_W  = sayac_w(ACLIK_SINIRI);
  localparam logic [AC_W-1:0] SINIR = AC_W'(ACLIK_SINIRI);

  logic [AC_W-1:0]  aclik;
  logic             tablo_yaz;
  logic             bos, dolu;
  erisim_e          erisim;
  logic [ADR_W-1:0] bas_adr;
  yuk_t             bas_yuk, giris_yuk;

  assign giris_yuk = '{ps: bus.yaz_ps_i, btb: bus.yaz_btb_i, yon: bus.yaz_yon_i};

  ongoru_kuyrugu #(
    .DERINLIK (DERINLIK),
    .ADR_W    (ADR_W)
  ) u_kuyruk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .temizle_i (temizle_i),
    .it_i      (bus.yaz_gecerli_i),
    .cek_i     (tablo_yaz),
    .adr_i     (bus.yaz_adr_i),
    .yuk_i     (giris_yuk),
    .bas_adr_o (bas_adr),
    .bas_yuk_o (bas_yuk),
    .bos_o     (bos),
    .dolu_o    (dolu)
  );

  // Reads win by default; a starved queue steals the port once the limit is hit.
  always_comb begin
    erisim = ERISIM_BOS;
    if (!bos && !temizle_i && (!bus.oku_istek_i || aclik == SINIR))
      erisim = ERISIM_YAZ;
    else if (bus.oku_istek_i)
      erisim = ERISIM_OKU;
  end

  assign tablo_yaz = (erisim == ERISIM_YAZ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aclik <= '0;
    end else if (temizle_i || bos || tablo_yaz) begin
      aclik <= '0;
    end else if (bus.oku_istek_i && aclik != SINIR) begin
      aclik <= aclik + AC_W'(1);
    end
  end

  assign bus.yaz_hazir_o = ~dolu;
  assign bus.oku_izin_o  = (erisim == ERISIM_OKU);
  assign bus.tablo_yaz_o = tablo_yaz;
  assign bus.tablo_adr_o = bas_adr;
  assign bus.tablo_ps_o  = bas_yuk.ps;
  assign bus.tablo_btb_o = bas_yuk.btb;
  assign bus.tablo_yon_o = bas_yuk.yon;
  assign bos_o           = bos;
  assign dolu_o          = dolu;

endmodule

// File: tb/tb_ongoru_guncelleme_siralayici.sv
// Scoreboard bench: accepted updates queue expected table writes; a negedge monitor checks them.
// Honours ONGORU_BIRLESTIRME_EN the same way the design does.
module tb_ongoru_guncelleme_siralayici;
  import ongoru_guncelleme_siralayici_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic [4:0]  adr;
    logic [30:0] ps;
    logic        btb;
    logic        yon;
  } ent_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic temizle_i = 1'b0;
  logic bos_o, dolu_o;

  ongoru_guncelleme_siralayici_if #(.ADR_W(5)) bus ();

  ongoru_guncelleme_siralayici #(
    .DERINLIK     (DEPTH),
    .ACLIK_SINIRI (LIMIT),
    .ADR_W        (5)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .temizle_i (temizle_i),
    .bus       (bus),
    .bos_o     (bos_o),
    .dolu_o    (dolu_o)
  );

  always #5 clk_i = ~clk_i;

  int   vec = 0;
  int   err = 0;
  int   denied = 0;
  ent_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of pending updates plus the count of reads granted past them.
  always @(negedge clk_i) begin
    int   n;
    logic exp_w, accept;
    ent_t e;
    if (!rst_ni) begin
      exp_q.delete();
      denied = 0;
      chk("rst_bos", 64'(bos_o), 64'd1);
      chk("rst_dolu", 64'(dolu_o), 64'd0);
      chk("rst_hazir", 64'(bus.yaz_hazir_o), 64'd1);
      chk("rst_yaz", 64'(bus.tablo_yaz_o), 64'd0);
      chk("rst_adr", 64'(bus.tablo_adr_o), 64'd0);
      chk("rst_ps", 64'(bus.tablo_ps_o), 64'd0);
      chk("rst_izin", 64'(bus.oku_izin_o), 64'(bus.oku_istek_i));
    end else begin
      n = exp_q.size();
      exp_w = (n != 0) && !temizle_i && (!bus.oku_istek_i || denied == LIMIT);
      chk("bos", 64'(bos_o), 64'(n == 0));
      chk("dolu", 64'(dolu_o), 64'(n == DEPTH));
      chk("hazir", 64'(bus.yaz_hazir_o), 64'(n != DEPTH));
      chk("tablo_yaz", 64'(bus.tablo_yaz_o), 64'(exp_w));
      chk("oku_izin", 64'(bus.oku_izin_o), 64'(bus.oku_istek_i && !exp_w));
      if (n != 0) begin
        chk("tablo_adr", 64'(bus.tablo_adr_o), 64'(exp_q[0].adr));
        chk("tablo_ps", 64'(bus.tablo_ps_o), 64'(exp_q[0].ps));
        chk("tablo_btb", 64'(bus.tablo_btb_o), 64'(exp_q[0].btb));
        chk("tablo_yon", 64'(bus.tablo_yon_o), 64'(exp_q[0].yon));
      end else begin
        chk("bos_veri", {bus.tablo_adr_o, bus.tablo_ps_o, bus.tablo_btb_o, bus.tablo_yon_o}, 64'd0);
      end
      accept = bus.yaz_gecerli_i && !temizle_i && (n < DEPTH);
      e = '{adr: bus.yaz_adr_i, ps: bus.yaz_ps_i, btb: bus.yaz_btb_i, yon: bus.yaz_yon_i};
      if (temizle_i) begin
        exp_q.delete();
        denied = 0;
      end else begin
        if (n == 0 || exp_w) denied = 0;
        else if (bus.oku_istek_i) denied = denied + 1;
        if (exp_w) void'(exp_q.pop_front());
        if (accept) begin
`ifdef ONGORU_BIRLESTIRME_EN
          if (exp_q.size() > 0 && exp_q[exp_q.size()-1].adr == e.adr)
            exp_q[exp_q.size()-1] = e;
          else
            exp_q.push_back(e);
`else
          exp_q.push_back(e);
`endif
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [4:0] a, input logic [30:0] p,
                     input logic b, input logic y, input logic o, input logic t);
    bus.yaz_gecerli_i = v;
    bus.yaz_adr_i     = a;
    bus.yaz_ps_i      = p;
    bus.yaz_btb_i     = b;
    bus.yaz_yon_i     = y;
    bus.oku_istek_i   = o;
    temizle_i         = t;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int k, input logic o);
    repeat (k) cyc(1'b0, 5'd0, 31'd0, 1'b0, 1'b0, o, 1'b0);
  endtask

  initial begin
    bus.yaz_gecerli_i = 1'b0;
    bus.yaz_adr_i     = '0;
    bus.yaz_ps_i      = '0;
    bus.yaz_btb_i     = 1'b0;
    bus.yaz_yon_i     = 1'b0;
    bus.oku_istek_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Reads only, nothing queued.
    idle(5, 1'b1);
    // Single push with the read port idle.
    cyc(1'b1, 5'd5, 31'h1000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    // Single push under continuous reads: forced write after the limit.
    cyc(1'b1, 5'd9, 31'h0ABC_DEF1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(12, 1'b1);
    idle(2, 1'b0);
    // Fill, over-fill, then drain in order.
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 5'(i), 31'(32'h100 * i), i[0], i[1], 1'b1, 1'b0);
    cyc(1'b1, 5'd12, 31'h7777, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(8, 1'b0);
    // Flush together with a push.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 5'(20 + i), 31'(32'h55 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd30, 31'h3333, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b0);
    // Same index twice while reads hold the port.
    cyc(1'b1, 5'd7, 31'h0000_0A0A, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd7, 31'h0000_0B0B, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    idle(4, 1'b0);
    // Asynchronous reset with entries pending.
    cyc(1'b1, 5'd3, 31'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd4, 31'h5678, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_ni = 1'b0;
    idle(2, 1'b1);
    rst_ni = 1'b1;
    idle(3, 1'b0);
    // Randomised traffic over a small index range so indices repeat.
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 31'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
    idle(10, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
